// File: rtl/ex_alu.sv
// Execute-stage RV32I integer ALU: registered result/zero flag behind valid/ready handshakes.
// Define EX_ALU_BARREL_SHIFT_EN for one-cycle barrel shifts; otherwise shifts iterate 1 bit per cycle.
module ex_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);
   localparam int SHW = $clog2(XLEN);

   // Handshake: an operation transfers on a rising edge with in_valid && in_ready;
   // a result transfers on a rising edge with out_valid && out_ready.

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_y;
   logic            out_free;
   logic            accept;

   assign shamt    = op_b[SHW-1:0];
   assign out_free = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      alu_y = '0;
      case (alu_control)
         4'b0000: alu_y = op_a + op_b;
         4'b1000: alu_y = op_a - op_b;
         4'b0010: alu_y = {{(XLEN-1){1'b0}},  ($signed(op_a) < $signed(op_b))};
         4'b1010: alu_y = {{(XLEN-1){1'b0}}, !($signed(op_a) < $signed(op_b))};
         4'b0011: alu_y = {{(XLEN-1){1'b0}},  (op_a < op_b)};
         4'b1011: alu_y = {{(XLEN-1){1'b0}}, !(op_a < op_b)};
         4'b0100: alu_y = op_a ^ op_b;
         4'b1100: alu_y = {{(XLEN-1){1'b0}}, (op_a == op_b)};
         4'b0110: alu_y = op_a | op_b;
         4'b0111: alu_y = op_a & op_b;
         4'b1111: alu_y = op_a + XLEN'(4);
`ifdef EX_ALU_BARREL_SHIFT_EN
         4'b0001: alu_y = op_a << shamt;
         4'b0101: alu_y = op_a >> shamt;
         4'b1101: alu_y = $signed(op_a) >>> shamt;
`else
         // Only reached on the one-cycle path, i.e. when shamt is zero.
         4'b0001, 4'b0101, 4'b1101: alu_y = op_a;
`endif
         default: alu_y = '0;
      endcase
   end

`ifdef EX_ALU_BARREL_SHIFT_EN
   assign in_ready = !rst && !flush && out_free;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         result    <= alu_y;
         zero      <= (alu_y == '0);
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`else
   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state;
   logic [SHW-1:0]  count;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] acc_next;
   logic            shift_left;
   logic            shift_arith;
   logic            is_shift;

   assign is_shift = (alu_control == 4'b0001) || (alu_control[2:0] == 3'b101);
   assign acc_next = shift_left ? {acc[XLEN-2:0], 1'b0}
                                : {shift_arith & acc[XLEN-1], acc[XLEN-1:1]};
   assign in_ready = !rst && !flush && (state == IDLE) && out_free;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         out_valid   <= 1'b0;
         result      <= '0;
         zero        <= 1'b1;
         count       <= '0;
         acc         <= '0;
         shift_left  <= 1'b0;
         shift_arith <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         count     <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_shift && shamt != '0) begin
                     acc         <= op_a;
                     count       <= shamt;
                     shift_left  <= !alu_control[2];
                     shift_arith <= alu_control[3];
                     state       <= SHIFT;
                  end else begin
                     result    <= alu_y;
                     zero      <= (alu_y == '0);
                     out_valid <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               acc   <= acc_next;
               count <= count - 1'b1;
               // Output register is guaranteed empty here: in_ready required it at accept.
               if (count == SHW'(1)) begin
                  result    <= acc_next;
                  zero      <= (acc_next == '0);
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_ex_alu.sv
// Scoreboard bench for ex_alu: driver tasks push expected {zero,result}; a negedge monitor pops and compares.
module tb_ex_alu;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a, op_b, result;

  logic [XLEN:0] exp_q[$];
  int            pop_cyc_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            pops = 0;

  ex_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [XLEN:0] got, input logic [XLEN:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h want=none", {zero, result});
      end else begin
        logic [XLEN:0] e;
        e = exp_q.pop_front();
        if ({zero, result} !== e) begin
          failures++;
          $display("FAIL result got=%h want=%h", {zero, result}, e);
        end
      end
      pop_cyc_q.push_back(cyc);
      pops++;
    end
  end

  // driver: call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] want, input bit push, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    alu_control = c; op_a = a; op_b = b; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        if (push) exp_q.push_back({(want == '0), want});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    acc_cyc  = cyc;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL issue_timeout code=%b got=no_accept want=accept", c);
    end
  endtask

  task automatic wait_pops(input int target);
    for (int n = 0; n < 200 && pops < target; n++) begin
      @(posedge clk); #1;
    end
    if (pops < target) begin
      checks++; failures++;
      $display("FAIL pop_timeout got=%0d want=%0d", pops, target);
    end
  endtask

  initial begin
    int a0, a1, a2, a3, p, lows, rise_cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; op_a = '0; op_b = '0;

    // reset
    @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_zero", zero, 1);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // back-to-back one-cycle ops
    p = pops;
    issue(4'b0000, 32'd5, 32'd7, 32'd12, 1, a0);
    issue(4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, a1);
    issue(4'b1100, 32'h1234, 32'h1234, 32'd1, 1, a2);
    issue(4'b1111, 32'h100, 32'd0, 32'h104, 1, a3);
    check("b2b_accept_span", a3 - a0, 3);
    wait_pops(p + 4);
    check("b2b_first_latency", pop_cyc_q[p] - a0, 0);
    check("b2b_no_bubbles", pop_cyc_q[p+3] - pop_cyc_q[p], 3);

    // sra by 4: latency and in_ready low cycles
    p = pops;
    issue(4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, a0);
    lows = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (pops > p) break;
      if (in_ready === 1'b0) lows++;
    end
    @(posedge clk); #1;
    wait_pops(p + 1);
`ifdef EX_ALU_BARREL_SHIFT_EN
    check("sra_latency", pop_cyc_q[p] - a0, 0);
`else
    check("sra_latency", pop_cyc_q[p] - a0, 4);
    check("sra_in_ready_low", lows, 4);
`endif

    p = pops;
    issue(4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, a0);
    wait_pops(p + 1);
    p = pops;
    issue(4'b0001, 32'h1234, 32'd0, 32'h1234, 1, a0);
    wait_pops(p + 1);
    check("sll0_latency", pop_cyc_q[p] - a0, 0);

    // compares and misc codes
    p = pops;
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, a0);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, a0);
    issue(4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, a0);
    issue(4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, a0);
    issue(4'b0100, 32'hABCD, 32'hABCD, 32'd0, 1, a0);
    issue(4'b1001, 32'd5, 32'd7, 32'd0, 1, a0);
    issue(4'b0111, 32'hFF, 32'h0F, 32'h0F, 1, a0);
    wait_pops(p + 7);

    // backpressure
    out_ready = 1'b0;
    p = pops;
    issue(4'b0000, 32'd10, 32'd20, 32'd30, 1, a0);
    alu_control = 4'b0110; op_a = 32'hF0; op_b = 32'h0F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", {out_valid, result}, {1'b1, 32'd30});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    rise_cyc = cyc;
    issue(4'b0110, 32'hF0, 32'h0F, 32'hFF, 1, a1);
    check("bp_accept_after_rise", a1 - rise_cyc, 1);
    wait_pops(p + 2);

    // flush during a long shift
    p = pops;
`ifdef EX_ALU_BARREL_SHIFT_EN
    issue(4'b0001, 32'd1, 32'd20, 32'h0010_0000, 1, a0);
`else
    issue(4'b0001, 32'd1, 32'd20, 32'h0010_0000, 0, a0);
`endif
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_out_valid", out_valid, 0);
    check("post_flush_in_ready", in_ready, 1);
`ifdef EX_ALU_BARREL_SHIFT_EN
    check("post_flush_result", {zero, result}, {1'b0, 32'h0010_0000});
`else
    check("post_flush_result", {zero, result}, {1'b0, 32'hFF});
`endif
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("flush_no_late_output", out_valid, 0);
    @(posedge clk); #1;
    p = pops;
    issue(4'b0000, 32'd3, 32'd4, 32'd7, 1, a0);
    wait_pops(p + 1);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
